// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared HDMI period constants, TMDS mode encoding and sequencer state enum
package hdmi_pkg;

  localparam logic [2:0] MODE_CONTROL      = 3'd0;
  localparam logic [2:0] MODE_VIDEO        = 3'd1;
  localparam logic [2:0] MODE_VIDEO_GUARD  = 3'd2;
  localparam logic [2:0] MODE_ISLAND_DATA  = 3'd3;
  localparam logic [2:0] MODE_ISLAND_GUARD = 3'd4;

  localparam logic [1:0] CTL_IDLE     = 2'b00;
  localparam logic [1:0] VID_PRE_CTL1 = 2'b01;
  localparam logic [1:0] VID_PRE_CTL2 = 2'b00;
  localparam logic [1:0] DI_PRE_CTL1  = 2'b01;
  localparam logic [1:0] DI_PRE_CTL2  = 2'b01;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;

  typedef enum logic [2:0] {
    ST_CONTROL,
    ST_VID_PRE,
    ST_VID_GUARD,
    ST_VIDEO,
    ST_DI_PRE,
    ST_DI_LEAD,
    ST_DI_DATA,
    ST_DI_TRAIL
  } state_t;

endpackage

// File: rtl/hdmi_period_sequencer.sv
// rtl/hdmi_period_sequencer.sv - per-pixel HDMI period FSM driving TMDS mode, ctl words and packet pacing
module hdmi_period_sequencer
  import hdmi_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int FRAME_WIDTH   = 800,
  parameter int FRAME_HEIGHT  = 525,
  parameter int MAX_PACKETS   = 18
) (
  input  logic                            clk_pixel,
  input  logic                            reset,
  input  logic [$clog2(FRAME_WIDTH)-1:0]  cx,
  input  logic [$clog2(FRAME_HEIGHT)-1:0] cy,
  input  logic                            hsync,
  input  logic                            vsync,
  output logic [2:0]                      mode,
  output logic [1:0]                      ctl0,
  output logic [1:0]                      ctl1,
  output logic [1:0]                      ctl2,
  output logic                            packet_enable,
  output logic [4:0]                      packet_pixel_counter
);

  localparam int CXW   = $clog2(FRAME_WIDTH);
  localparam int CYW   = $clog2(FRAME_HEIGHT);
  localparam int HB    = FRAME_WIDTH - SCREEN_WIDTH;
  localparam int N_FIT = (HB - 28) / 32;
  localparam int N     = (N_FIT < MAX_PACKETS) ? N_FIT : MAX_PACKETS;
  localparam bit ISLANDS_EN = (HB >= 60) && (N > 0);

  localparam logic [4:0]     LAST_PACKET  = 5'(ISLANDS_EN ? N - 1 : 0);
  localparam logic [4:0]     PRE_LOAD     = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0]     GUARD_LOAD   = 5'(GUARD_LEN - 1);
  localparam logic [4:0]     PIX_LAST     = 5'(PACKET_LEN - 1);
  localparam logic [CXW-1:0] ISLAND_START = CXW'(SCREEN_WIDTH + 2);
  localparam logic [CXW-1:0] LEAD_START   = CXW'(FRAME_WIDTH - 10);
  localparam logic [CXW-1:0] ACTIVE_W     = CXW'(SCREEN_WIDTH);
  localparam logic [CYW-1:0] LAST_ACTIVE  = CYW'(SCREEN_HEIGHT - 1);
  localparam logic [CYW-1:0] LAST_LINE    = CYW'(FRAME_HEIGHT - 1);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] pkt_q, pkt_d;
  logic [4:0] pix_q, pix_d;
  logic [2:0] mode_q, mode_d;
  logic [1:0] ctl0_q, ctl0_d;
  logic [1:0] ctl1_q, ctl1_d;
  logic [1:0] ctl2_q, ctl2_d;
  logic       pe_q, pe_d;
  logic       next_active;
  logic       in_active;

  // state_d is the period of the pixel currently on cx; counters hold that pixel's position
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pkt_d       = 5'd0;
    pix_d       = 5'd0;
    next_active = (cy < LAST_ACTIVE) || (cy == LAST_LINE);
    in_active   = cx < ACTIVE_W;
    case (state_q)
      ST_CONTROL: begin
        if (ISLANDS_EN && cx == ISLAND_START) begin
          state_d = ST_DI_PRE;
          cnt_d   = PRE_LOAD;
        end else if (cx == LEAD_START && next_active) begin
          state_d = ST_VID_PRE;
          cnt_d   = PRE_LOAD;
        end
      end
      ST_VID_PRE: begin
        if (cnt_q == 5'd0) begin
          state_d = ST_VID_GUARD;
          cnt_d   = GUARD_LOAD;
        end else cnt_d = cnt_q - 5'd1;
      end
      ST_VID_GUARD: begin
        if (cnt_q == 5'd0) state_d = in_active ? ST_VIDEO : ST_CONTROL;
        else               cnt_d = cnt_q - 5'd1;
      end
      ST_VIDEO: begin
        if (!in_active) state_d = ST_CONTROL;
      end
      ST_DI_PRE: begin
        if (cnt_q == 5'd0) begin
          state_d = ST_DI_LEAD;
          cnt_d   = GUARD_LOAD;
        end else cnt_d = cnt_q - 5'd1;
      end
      ST_DI_LEAD: begin
        if (cnt_q == 5'd0) state_d = ST_DI_DATA;
        else               cnt_d = cnt_q - 5'd1;
      end
      ST_DI_DATA: begin
        if (pix_q == PIX_LAST && pkt_q == LAST_PACKET) begin
          state_d = ST_DI_TRAIL;
          cnt_d   = GUARD_LOAD;
        end else begin
          pix_d = pix_q + 5'd1;
          pkt_d = (pix_q == PIX_LAST) ? pkt_q + 5'd1 : pkt_q;
        end
      end
      ST_DI_TRAIL: begin
        if (cnt_q == 5'd0) state_d = ST_CONTROL;
        else               cnt_d = cnt_q - 5'd1;
      end
      default: state_d = ST_CONTROL;
    endcase
  end

  always_comb begin
    mode_d = MODE_CONTROL;
    ctl1_d = CTL_IDLE;
    ctl2_d = CTL_IDLE;
    ctl0_d = {vsync, hsync};
    pe_d   = (state_d == ST_DI_DATA) && (pix_d == 5'd0);
    case (state_d)
      ST_VID_PRE: begin
        ctl1_d = VID_PRE_CTL1;
        ctl2_d = VID_PRE_CTL2;
      end
      ST_VID_GUARD: mode_d = MODE_VIDEO_GUARD;
      ST_VIDEO:     mode_d = MODE_VIDEO;
      ST_DI_PRE: begin
        ctl1_d = DI_PRE_CTL1;
        ctl2_d = DI_PRE_CTL2;
      end
      ST_DI_LEAD, ST_DI_TRAIL: mode_d = MODE_ISLAND_GUARD;
      ST_DI_DATA:   mode_d = MODE_ISLAND_DATA;
      default:      mode_d = MODE_CONTROL;
    endcase
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q <= ST_CONTROL;
      cnt_q   <= 5'd0;
      pkt_q   <= 5'd0;
      pix_q   <= 5'd0;
      mode_q  <= MODE_CONTROL;
      ctl0_q  <= CTL_IDLE;
      ctl1_q  <= CTL_IDLE;
      ctl2_q  <= CTL_IDLE;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
      pix_q   <= pix_d;
      mode_q  <= mode_d;
      ctl0_q  <= ctl0_d;
      ctl1_q  <= ctl1_d;
      ctl2_q  <= ctl2_d;
      pe_q    <= pe_d;
    end
  end

  assign mode                 = mode_q;
  assign ctl0                 = ctl0_q;
  assign ctl1                 = ctl1_q;
  assign ctl2                 = ctl2_q;
  assign packet_enable        = pe_q;
  assign packet_pixel_counter = pix_q;

endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// tb/tb_hdmi_period_sequencer.sv - scoreboard bench for three sequencer configurations under random syncs
module tb_hdmi_period_sequencer;

  localparam int SW = 640, SH = 480, FW = 800, FH = 525, FWC = 690;
  localparam int RST_LINE = 6, RST_AT = 700, RST_LEN = 5;

  typedef struct packed {
    logic [2:0] mode;
    logic [1:0] ctl0;
    logic [1:0] ctl1;
    logic [1:0] ctl2;
    logic       pe;
    logic [4:0] ppc;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
    exp_t c;
  } trio_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_ab, rst_c;
  logic [9:0] cx_ab, cy_ab, cx_c, cy_c;
  logic       hs_ab, vs_ab, hs_c, vs_c;

  logic [2:0] mode_a, mode_b, mode_c;
  logic [1:0] ctl0_a, ctl1_a, ctl2_a, ctl0_b, ctl1_b, ctl2_b, ctl0_c, ctl1_c, ctl2_c;
  logic       pe_a, pe_b, pe_c;
  logic [4:0] ppc_a, ppc_b, ppc_c;

  hdmi_period_sequencer #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .FRAME_WIDTH(FW),
                          .FRAME_HEIGHT(FH), .MAX_PACKETS(18)) dut_a (
    .clk_pixel(clk), .reset(rst_ab), .cx(cx_ab), .cy(cy_ab), .hsync(hs_ab), .vsync(vs_ab),
    .mode(mode_a), .ctl0(ctl0_a), .ctl1(ctl1_a), .ctl2(ctl2_a),
    .packet_enable(pe_a), .packet_pixel_counter(ppc_a));

  hdmi_period_sequencer #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .FRAME_WIDTH(FW),
                          .FRAME_HEIGHT(FH), .MAX_PACKETS(1)) dut_b (
    .clk_pixel(clk), .reset(rst_ab), .cx(cx_ab), .cy(cy_ab), .hsync(hs_ab), .vsync(vs_ab),
    .mode(mode_b), .ctl0(ctl0_b), .ctl1(ctl1_b), .ctl2(ctl2_b),
    .packet_enable(pe_b), .packet_pixel_counter(ppc_b));

  hdmi_period_sequencer #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .FRAME_WIDTH(FWC),
                          .FRAME_HEIGHT(FH), .MAX_PACKETS(18)) dut_c (
    .clk_pixel(clk), .reset(rst_c), .cx(cx_c), .cy(cy_c), .hsync(hs_c), .vsync(vs_c),
    .mode(mode_c), .ctl0(ctl0_c), .ctl1(ctl1_c), .ctl2(ctl2_c),
    .packet_enable(pe_c), .packet_pixel_counter(ppc_c));

  exp_t  act_a, act_b, act_c;
  assign act_a = {mode_a, ctl0_a, ctl1_a, ctl2_a, pe_a, ppc_a};
  assign act_b = {mode_b, ctl0_b, ctl1_b, ctl2_b, pe_b, ppc_b};
  assign act_c = {mode_c, ctl0_c, ctl1_c, ctl2_c, pe_c, ppc_c};

  trio_t sb[$];
  int    passed = 0;
  int    total  = 0;

  function automatic bit next_active(input int cy);
    return (cy < SH - 1) || (cy == FH - 1);
  endfunction

  // Positional model: the period of a pixel follows from its column and whether this line's
  // island / lead-in and the previous line's lead-in actually happened.
  function automatic exp_t model(input int x, input int sw, input int fw, input int maxp,
                                 input bit isl_ok, input bit lead_ok, input bit vid_ok,
                                 input logic [1:0] syncs, input bit in_rst);
    exp_t e;
    int   hb, n, is, d, vs;
    e = '0;
    if (in_rst) return e;
    e.ctl0 = syncs;
    hb = fw - sw;
    n  = (hb - 28) / 32;
    if (n > maxp) n = maxp;
    is = sw + 2;
    d  = is + 10;
    vs = fw - 10;
    if (isl_ok && hb >= 60 && n > 0 && x >= is && x < d + 32 * n + 2) begin
      if (x < is + 8) begin
        e.ctl1 = 2'b01;
        e.ctl2 = 2'b01;
      end else if (x < d || x >= d + 32 * n) begin
        e.mode = 3'd4;
      end else begin
        e.mode = 3'd3;
        e.ppc  = 5'((x - d) % 32);
        e.pe   = ((x - d) % 32) == 0;
      end
    end else if (lead_ok && x >= vs) begin
      if (x < vs + 8) e.ctl1 = 2'b01;
      else            e.mode = 3'd2;
    end else if (vid_ok && x < sw) begin
      e.mode = 3'd1;
    end
    return e;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp, input int n);
    total++;
    if (act !== exp)
      $display("FAIL %s sample=%0d actual mode=%0d ctl0=%b ctl1=%b ctl2=%b pe=%b ppc=%0d required mode=%0d ctl0=%b ctl1=%b ctl2=%b pe=%b ppc=%0d",
               name, n, act.mode, act.ctl0, act.ctl1, act.ctl2, act.pe, act.ppc,
               exp.mode, exp.ctl0, exp.ctl1, exp.ctl2, exp.pe, exp.ppc);
    else
      passed++;
  endtask

  initial begin
    trio_t t;
    int    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        t = sb.pop_front();
        check("dut_a_max18", act_a, t.a, n);
        check("dut_b_max1", act_b, t.b, n);
        check("dut_c_hb50", act_c, t.c, n);
        n++;
      end
    end
  end

  initial begin
    int    lines[$];
    trio_t t;
    int    cy, cxc, cyc, guard;
    bit    lead, prev_lead_ab, prev_lead_c;

    rst_ab = 1'b1; rst_c = 1'b1;
    cx_ab = '0; cy_ab = '0; cx_c = '0; cy_c = '0;
    hs_ab = 1'b0; vs_ab = 1'b0; hs_c = 1'b0; vs_c = 1'b0;
    repeat (3) begin
      @(negedge clk);
      hs_ab = 1'($urandom_range(0, 1));
      vs_ab = 1'($urandom_range(0, 1));
      t.a = model(0, SW, FW, 18, 1'b0, 1'b0, 1'b0, {vs_ab, hs_ab}, 1'b1);
      t.b = t.a;
      t.c = t.a;
      sb.push_back(t);
    end

    lines = '{9, 10, 11, 479, 524, 0, 200};
    for (int k = 0; k < 5; k++) lines.push_back(int'($urandom_range(0, FH - 1)));

    prev_lead_ab = 1'b0;
    prev_lead_c  = 1'b0;
    cxc = 0;
    cyc = int'($urandom_range(0, FH - 1));
    foreach (lines[li]) begin
      cy   = lines[li];
      lead = next_active(cy);
      for (int x = 0; x < FW; x++) begin
        @(negedge clk);
        rst_ab = (li == RST_LINE) && x >= RST_AT && x < RST_AT + RST_LEN;
        rst_c  = 1'b0;
        cx_ab  = 10'(x);
        cy_ab  = 10'(cy);
        hs_ab  = 1'($urandom_range(0, 1));
        vs_ab  = 1'($urandom_range(0, 1));
        cx_c   = 10'(cxc);
        cy_c   = 10'(cyc);
        hs_c   = 1'($urandom_range(0, 1));
        vs_c   = 1'($urandom_range(0, 1));
        t.a = model(x, SW, FW, 18, !(li == RST_LINE && x >= RST_AT), lead, prev_lead_ab,
                    {vs_ab, hs_ab}, rst_ab);
        t.b = model(x, SW, FW, 1, !(li == RST_LINE && x >= RST_AT), lead, prev_lead_ab,
                    {vs_ab, hs_ab}, rst_ab);
        t.c = model(cxc, SW, FWC, 18, 1'b1, next_active(cyc), prev_lead_c, {vs_c, hs_c}, 1'b0);
        sb.push_back(t);
        cxc++;
        if (cxc == FWC) begin
          cxc         = 0;
          prev_lead_c = next_active(cyc);
          cyc         = int'($urandom_range(0, FH - 1));
        end
      end
      prev_lead_ab = lead;
    end

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    total++;
    if (sb.size() > 0)
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
